// File: rtl/memory_responder.sv
// Responder end of the core memory valid/ready interface.
// Word-organised RAM with programmable access latency for fetches and data.
`timescale 1ns/1ps
module memory_responder #(
    parameter int unsigned DEPTH_WORDS   = 4096,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned DATA_LATENCY  = 1,
    parameter int unsigned INSTR_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [31:0] DLAT = DATA_LATENCY;
    localparam logic [31:0] ILAT = INSTR_LATENCY;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic [31:0]   lat;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] index;
    logic          is_write;

    // Decode the captured request against the RAM window.
    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign index    = offset[AW+1:2];
    assign is_write = (wstrb_q != 4'h0);

    // Byte offset bits and the captured fetch flag carry no datapath use.
    logic unused_ok;
    assign unused_ok = ^{offset[31:AW+2], offset[1:0], instr_q};

    // Next-state: accept in IDLE/RESP, count wait states, pulse RESP once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        instr_d = instr_q;
        accept  = memory_valid && (state_q != WAIT);
        lat     = memory_instr ? ILAT : DLAT;
        if (accept) begin
            addr_d  = memory_addr;
            wdata_d = memory_wdata;
            wstrb_d = memory_wstrb;
            instr_d = memory_instr;
            if (lat <= 32'd1) begin
                state_d = RESP;
                cnt_d   = 32'd0;
            end else begin
                state_d = WAIT;
                cnt_d   = lat - 32'd1;
            end
        end else begin
            case (state_q)
                RESP: begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                end
                WAIT: begin
                    if (cnt_q <= 32'd1) begin
                        state_d = RESP;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs: ready only in RESP; read data gated to zero otherwise.
    always_comb begin
        memory_ready = (state_q == RESP);
        memory_rdata = 32'h0;
        if (state_q == RESP && !is_write && in_range) begin
            memory_rdata = mem_q[index];
        end
    end

    // Request and FSM registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            instr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
        end
    end

    // Writes commit at the edge closing the ready cycle; reset cancels them.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && is_write && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[index][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three latency/base configurations,
// each driven by directed and random traffic against an edge-count model.
`timescale 1ns/1ps
module tb_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit done [3];

    function automatic void chk(input int cfg, input string nm,
                                input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cfg%0d %s: got %h want %h", cfg, nm, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int unsigned D    = 64;
        localparam int unsigned DL   = (g == 0) ? 1 : (g == 1) ? 2 : 3;
        localparam int unsigned IL   = (g == 1) ? 4 : 1;
        localparam logic [31:0] BASE = (g == 2) ? 32'h8000_0000 : 32'h0;

        logic        rst   = 1'b1;
        logic        valid = 1'b0;
        logic        instr = 1'b0;
        logic [31:0] addr  = '0;
        logic [31:0] wdata = '0;
        logic [3:0]  wstrb = '0;
        logic [31:0] rdata;
        logic        ready;

        memory_responder #(
            .DEPTH_WORDS  (D),
            .BASE_ADDR    (BASE),
            .DATA_LATENCY (DL),
            .INSTR_LATENCY(IL)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .memory_valid(valid),
            .memory_instr(instr),
            .memory_addr (addr),
            .memory_wdata(wdata),
            .memory_wstrb(wstrb),
            .memory_rdata(rdata),
            .memory_ready(ready)
        );

        // Model: one outstanding request, ready in the cycle ending at edge e+L.
        logic [31:0] mm [D];
        int          ecount   = 0;
        bit          pend     = 0;
        int          pend_end = 0;
        bit          p_wr     = 0;
        bit          p_inr    = 0;
        int          p_idx    = 0;
        logic [31:0] p_wd     = '0;
        logic [31:0] p_rd     = '0;
        logic [3:0]  p_ws     = '0;
        bit          armed    = 0;

        function automatic void model_edge(input bit v, input bit ins,
                                           input logic [31:0] a, input logic [31:0] wd,
                                           input logic [3:0] ws, input bit r);
            longint unsigned off;
            int unsigned lt;
            ecount++;
            if (r) begin
                pend = 0;
            end else begin
                if (pend && pend_end == ecount) begin
                    if (p_wr && p_inr)
                        for (int i = 0; i < 4; i++)
                            if (p_ws[i]) mm[p_idx][8*i +: 8] = p_wd[8*i +: 8];
                    pend = 0;
                end
                if (v && !pend) begin
                    lt    = ins ? IL : DL;
                    off   = longint'(a) - longint'(BASE);
                    p_inr = (a >= BASE) && (off < longint'(4 * D));
                    p_idx = p_inr ? int'(off / 4) : 0;
                    p_wr  = (ws != 4'h0);
                    p_wd  = wd;
                    p_ws  = ws;
                    p_rd  = (!p_wr && p_inr) ? mm[p_idx] : 32'h0;
                    pend     = 1;
                    pend_end = ecount + int'(lt);
                end
            end
        endfunction

        task automatic step(input bit v, input bit ins, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws, input bit r);
            #1;
            valid = v;
            instr = ins;
            addr  = a;
            wdata = wd;
            wstrb = ws;
            rst   = r;
            @(posedge clk);
            model_edge(v, ins, a, wd, ws, r);
        endtask

        task automatic xfer(input bit ins, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input bit noise,
                            output bit seen, output int lat, output logic [31:0] dat);
            seen = 0;
            lat  = 0;
            dat  = '0;
            step(1, ins, a, wd, ws, 0);
            for (int i = 1; i <= 16 && !seen; i++) begin
                @(negedge clk);
                if (ready) begin
                    seen = 1;
                    lat  = i;
                    dat  = rdata;
                end
                step(noise && !seen, 0, $urandom, 32'h0, 4'h0, 0);
            end
        endtask

        task automatic idle(input int n, output int nrdy);
            nrdy = 0;
            repeat (n) begin
                @(negedge clk);
                if (ready) nrdy++;
                step(0, 0, 32'h0, 32'h0, 4'h0, 0);
            end
        endtask

        // Every cycle: DUT ready/rdata must match the model.
        always @(negedge clk) begin
            logic        er;
            logic [31:0] ed;
            if (armed) begin
                er = pend && (pend_end == ecount + 1);
                ed = er ? p_rd : 32'h0;
                chk(g, "ready", {31'b0, ready}, {31'b0, er});
                chk(g, "rdata", rdata, ed);
            end
        end

        initial begin
            bit          s;
            bit          ok;
            int          l;
            int          n;
            int          k;
            logic [31:0] d;
            logic [31:0] bb_d [4];
            int          bb_t [4];
            logic [31:0] ra;

            step(0, 0, 32'h0, 32'h0, 4'h0, 1);
            step(0, 0, 32'h0, 32'h0, 4'h0, 1);
            @(negedge clk);
            chk(g, "rst_ready", {31'b0, ready}, 32'h0);
            chk(g, "rst_rdata", rdata, 32'h0);
            armed = 1;

            ok = 1;
            for (int w = 0; w < D; w++) begin
                xfer(0, BASE + 32'(w * 4), 32'hC0DE0000 + 32'(w), 4'hF, 0, s, l, d);
                if (!s) ok = 0;
            end
            chk(g, "preload_acks", {31'b0, ok}, 32'd1);

            xfer(0, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, s, l, d);
            chk(g, "wr_lat", 32'(l), 32'(DL));
            chk(g, "wr_rdata", d, 32'h0);
            xfer(0, BASE + 32'h10, 32'h0, 4'h0, 0, s, l, d);
            chk(g, "rd_lat", 32'(l), 32'(DL));
            chk(g, "rd_data", d, 32'hDEADBEEF);

            xfer(0, BASE + 32'h10, 32'h00AA0000, 4'b0100, 0, s, l, d);
            xfer(0, BASE + 32'h10, 32'h0, 4'h0, 0, s, l, d);
            chk(g, "strobe_data", d, 32'hDEAABEEF);

            xfer(1, BASE + 32'h8, 32'h0, 4'h0, 1, s, l, d);
            chk(g, "fetch_lat", 32'(l), 32'(IL));
            chk(g, "fetch_data", d, 32'hC0DE0002);
            idle(8, n);
            chk(g, "wait_noise", 32'(n), 32'd0);

            k = 0;
            step(1, 0, BASE, 32'h0, 4'h0, 0);
            for (int c = 0; c < 40 && k < 4; c++) begin
                @(negedge clk);
                if (ready) begin
                    bb_d[k] = rdata;
                    bb_t[k] = c;
                    k++;
                end
                step(k < 4, 0, BASE + 32'(k * 4), 32'h0, 4'h0, 0);
            end
            chk(g, "bb_count", 32'(k), 32'd4);
            chk(g, "bb_d0", bb_d[0], 32'hC0DE0000);
            chk(g, "bb_d1", bb_d[1], 32'hC0DE0001);
            chk(g, "bb_d2", bb_d[2], 32'hC0DE0002);
            chk(g, "bb_d3", bb_d[3], 32'hC0DE0003);
            chk(g, "bb_first", 32'(bb_t[0]), 32'(DL - 1));
            for (int j = 0; j < 3; j++)
                chk(g, "bb_gap", 32'(bb_t[j+1] - bb_t[j]), 32'(DL));

            xfer(0, BASE ^ 32'h8000_0000, 32'h0, 4'h0, 0, s, l, d);
            chk(g, "oor_rd_ack", {31'b0, s}, 32'd1);
            chk(g, "oor_rd_data", d, 32'h0);
            xfer(0, BASE + 32'(4 * D), 32'hFFFFFFFF, 4'hF, 0, s, l, d);
            chk(g, "oor_wr_ack", {31'b0, s}, 32'd1);
            xfer(0, BASE, 32'h0, 4'h0, 0, s, l, d);
            chk(g, "oor_word0", d, 32'hC0DE0000);
            xfer(0, BASE + 32'(4 * (D - 1)), 32'h0, 4'h0, 0, s, l, d);
            chk(g, "oor_wordlast", d, 32'hC0DE003F);

            step(1, 0, BASE + 32'h20, 32'h12345678, 4'hF, 0);
            step(0, 0, 32'h0, 32'h0, 4'h0, 1);
            idle(8, n);
            chk(g, "rst_drop", 32'(n), 32'd0);
            xfer(0, BASE + 32'h20, 32'h0, 4'h0, 0, s, l, d);
            chk(g, "rst_keep", d, 32'hC0DE0008);

            for (int c = 0; c < 1500; c++) begin
                if ($urandom % 5 != 0)
                    ra = BASE + (($urandom % D) << 2) + ($urandom % 4);
                else
                    ra = $urandom;
                step(($urandom % 3) != 0, $urandom % 2, ra, $urandom,
                     ($urandom % 2) ? 4'h0 : 4'($urandom), ($urandom % 150) == 0);
            end
            idle(10, n);
            done[g] = 1;
        end
    end

    initial begin
        for (int c = 0; c < 60000; c++) begin
            if (done[0] && done[1] && done[2]) break;
            @(posedge clk);
        end
        if (!(done[0] && done[1] && done[2])) begin
            total++;
            bad++;
            $display("FAIL timeout: done=%0d%0d%0d want 111", done[0], done[1], done[2]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
